instruction_cache: RTL
======================

# instruction_cache

Direct-mapped, read-only instruction cache between the CPU fetch port and the 64×16-byte block instruction memory. Holds 8 blocks of 16 bytes (128 bytes total), returns a 32-bit instruction on a hit with no stall, and on a miss stalls the CPU while it fetches the whole 16-byte block from instruction memory. Block fills are the only writes; there is no write path from the CPU.

## Interface
- (no parameters): geometry is fixed at 8 blocks × 16 bytes, 10-bit byte address, 3-bit tag, 3-bit index, 4-bit offset.
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; clears cache and FSM when 0.
- pc_address  in  10  CPU byte address of the instruction; bits[1:0] ignored (word-aligned).
- instruction  out  32  selected instruction word; valid when cpu_busywait=0.
- cpu_busywait  out  1  stall to CPU; high while a lookup misses or a fill is in progress.
- mem_read  out  1  read request to instruction memory.
- mem_address  out  6  block address to instruction memory, {tag, index}.
- mem_readinst  in  128  block returned by memory; byte 0 in bits[7:0].
- mem_busywait  in  1  memory busy; fill data valid when it falls low.

## Operation
- Address split: tag = pc_address[9:7], index = pc_address[6:4], word = pc_address[3:2].
- Storage per entry: valid (1), tag (3), data (128). Word w occupies data[32w+31:32w].
- hit = valid[index] && (tag_store[index] == tag); combinational from pc_address.
- instruction = data[index] word selected by pc_address[3:2]; combinational.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE: hit → cpu_busywait=0, stay. Miss → cpu_busywait=1; next state MEM_READ.
- MEM_READ: mem_read=1, mem_address={tag,index} from pc_address (CPU holds pc_address stable while stalled); cpu_busywait=1. Stay while mem_busywait=1; on posedge with mem_busywait=0 → UPDATE.
- UPDATE: mem_read=0; on the posedge ending this state, write data[index]=mem_readinst, tag_store[index]=tag, valid[index]=1; → IDLE. cpu_busywait=1 throughout.
- Return to IDLE: lookup re-evaluates, now hits, cpu_busywait falls.
- Replacement: direct-mapped, new block unconditionally overwrites index; no dirty state.
- Reset (reset=0, any state, any time): state←IDLE, all valid←0, mem_read←0, mem_address←0; any in-flight fill is discarded and no entry is written. Tags and data need not be cleared.
- Outputs while reset=0: cpu_busywait=0, mem_read=0, mem_address=6'd0, instruction=32'd0.

## Timing
- Hit: zero stall cycles; tag compare settles within #0.9, instruction within #1 of pc_address change.
- Miss detect: cpu_busywait rises within #1 of pc_address change in IDLE.
- mem_read asserted from first posedge after miss detection; held continuously until MEM_READ exits.
- Miss penalty: 1 (IDLE→MEM_READ) + memory busy cycles + 1 (UPDATE) cycles; cpu_busywait falls ~#1 after UPDATE ends.
- Cache array write in UPDATE completes with #1 after posedge.
- mem_busywait high for arbitrarily many cycles: FSM waits indefinitely, mem_address stable.
- mem_busywait already low at first MEM_READ posedge: memory has not yet accepted; FSM requires mem_read seen for ≥1 posedge before mem_busywait=0 is taken as completion.
- Reset deasserted: first posedge after release operates normally; first lookup misses.

## Test plan
- Reset, then pc_address=0 → cpu_busywait=1, mem_read=1, mem_address=6'd0; after mem_busywait falls and UPDATE, instruction=32'h00040019, cpu_busywait=0.
- After that fill, pc_address=4, 8, 12 on successive cycles → no stall; instruction=32'h00050023, 32'h02060405, 32'h0001005A; mem_read stays 0.
- pc_address=16 → miss, mem_address=6'd1; after fill, pc_address=20 hits with instruction=32'h02010506.
- Conflict: pc_address=10'h080 (tag 1, index 0) → miss, mem_address=6'h08, evicts block 0; then pc_address=0 misses again and refetches mem_address=6'd0.
- reset=0 pulsed mid MEM_READ (mem_busywait high) → mem_read and cpu_busywait drop immediately, state IDLE; after release pc_address=16 (previously filled) misses.
- mem_busywait held high 50 cycles → FSM stays MEM_READ, mem_read=1, mem_address unchanged, cpu_busywait=1 every cycle.

Source files
------------

// File: rtl/instruction_cache.sv
// Direct-mapped read-only I-cache, 8 x 16-byte blocks: hits return a word combinationally with zero stall.
// Misses stall the CPU via cpu_busywait for 1 + memory busy cycles + 1 while the whole block is fetched.
module instruction_cache (
  input  logic         clock,
  input  logic         reset,
  input  logic [9:0]   pc_address,
  output logic [31:0]  instruction,
  output logic         cpu_busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readinst,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [7:0]   valid;
  logic [2:0]   tag_mem  [8];
  logic [127:0] data_mem [8];

  logic [2:0] tag;
  logic [2:0] index;
  logic [1:0] word;
  logic       hit;
  logic       req_seen;
  logic       unused_addr_bits;

  assign tag              = pc_address[9:7];
  assign index            = pc_address[6:4];
  assign word             = pc_address[3:2];
  assign unused_addr_bits = ^pc_address[1:0];

  assign hit = valid[index] && (tag_mem[index] == tag);

  // Memory may still show mem_busywait low from its idle state on the first
  // MEM_READ edge, so completion only counts once mem_read has been sampled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req_seen <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_seen <= (state == MEM_READ) && (state_nxt == MEM_READ);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (!hit) state_nxt = MEM_READ;
      MEM_READ: if (req_seen && !mem_busywait) state_nxt = UPDATE;
      UPDATE:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu_busywait = 1'b0;
    mem_read     = 1'b0;
    mem_address  = 6'd0;
    instruction  = 32'd0;
    if (reset) begin
      instruction  = data_mem[index][{word, 5'd0} +: 32];
      cpu_busywait = (state != IDLE) || !hit;
      mem_read     = (state == MEM_READ);
      // Address is held through UPDATE so the memory keeps presenting the block.
      if (state != IDLE) mem_address = {tag, index};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid <= 8'd0;
    end else if (state == UPDATE) begin
      valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset && state == UPDATE) begin
      data_mem[index] <= mem_readinst;
      tag_mem[index]  <= tag;
    end
  end

endmodule
